// File: rtl/instr_fetch_unit_if.sv
// Purpose : bundles the fetch unit's controller-side and instruction-memory-side
//           signals so they travel as one port.
// Ports   : master = fetch unit (drives imem request, instruction, pc, status);
//           slave  = environment (controller + instruction memory).
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    // controller side
    logic              fetch_req;
    logic [3:0]        stat;
    logic [31:0]       instr;
    logic [3:0]        opcode;
    logic [3:0]        mm;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;

    // instruction memory side
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_data;

    modport master (
        input  fetch_req, stat, imem_ack, imem_data,
        output imem_rd, imem_addr, instr, opcode, mm, instr_valid, pc, busy, halted
    );

    modport slave (
        output fetch_req, stat, imem_ack, imem_data,
        input  imem_rd, imem_addr, instr, opcode, mm, instr_valid, pc, busy, halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose : holds the PC, fetches one instruction word per fetch_req over a
//           request/ack handshake, latches it and resolves the next PC
//           (sequential, bra, brr, bne, hlt).
// Ports   : clk, rst (async, active-high); bus = instr_fetch_unit_if.master.
//           Fetch takes IDLE -> REQ (waits for imem_ack) -> RESOLVE -> IDLE/HALT;
//           minimum period 3 cycles, requests outside IDLE are dropped.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_unit_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_HLT = 4'd15;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic              imem_rd;
    logic              instr_valid;
    logic              busy;
    logic              halted;

    logic [3:0]        opcode;
    logic [3:0]        mm;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] next_pc;

    assign opcode = instr[31:28];
    assign mm     = instr[27:24];

    // Sign-extend the 16-bit branch offset to ADDR_W; for narrow PCs the
    // upper offset bits simply fall away, which keeps the math modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] sext_offset(input logic [15:0] v);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = (i < 16) ? v[i[3:0]] : v[15];
        end
        return r;
    endfunction

    assign offset = sext_offset(instr[15:0]);

    // Next PC is evaluated only in RESOLVE, where instr already holds the new
    // word and stat is sampled for bne.
    always_comb begin
        next_pc = pc + ADDR_W'(1);
        case (opcode)
            OP_BRA: next_pc = instr[ADDR_W-1:0];
            OP_BRR: next_pc = pc + offset;
            OP_BNE: begin
                if ((bus.stat & mm) == 4'b0000) begin
                    next_pc = pc + offset;
                end
            end
            default: ;
        endcase
    end

    // Single FSM; every output is a register updated alongside the state so
    // nothing downstream sees decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            imem_rd     <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.fetch_req) begin
                        state   <= ST_REQ;
                        imem_rd <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // imem_rd and imem_addr (= pc) stay put until the ack lands.
                    if (bus.imem_ack) begin
                        state       <= ST_RESOLVE;
                        instr       <= bus.imem_data;
                        imem_rd     <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ST_RESOLVE: begin
                    instr_valid <= 1'b0;
                    busy        <= 1'b0;
                    if (opcode == OP_HLT) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        pc    <= next_pc;
                    end
                end
                ST_HALT: begin
                    // Sticky until reset; fetch_req and imem_ack are ignored.
                    halted <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_rd     = imem_rd;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr;
    assign bus.opcode      = opcode;
    assign bus.mm          = mm;
    assign bus.instr_valid = instr_valid;
    assign bus.pc          = pc;
    assign bus.busy        = busy;
    assign bus.halted      = halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : directed self-checking bench for instr_fetch_unit (ADDR_W=16,
//           RESET_PC=0x0010): reset, delayed ack, bra/brr/bne, PC wrap, hlt,
//           and reset in the middle of a request.
module tb_instr_fetch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   vcount;

    instr_fetch_unit_if #(.ADDR_W(16)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (16),
        .RESET_PC (16'h0010)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count instr_valid pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.instr_valid === 1'b1) vcount++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete fetch. The request is raised for one cycle, the ack comes
    // after 'delay' extra REQ cycles, and a stray fetch_req is injected at wait
    // cycle 'drop_at' (negative = none). Ends one cycle after RESOLVE.
    task automatic fetch(input logic [31:0] data, input int delay, input int drop_at,
                         input logic [15:0] exp_addr, input logic [15:0] exp_next);
        int v0;
        @(negedge clk);
        bus.fetch_req = 1'b1;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        v0 = vcount;
        for (int i = 0; i < delay; i++) begin
            check("wait_rd", bus.imem_rd, 1);
            check("wait_addr", bus.imem_addr, exp_addr);
            bus.fetch_req = (i == drop_at);
            @(negedge clk);
        end
        bus.fetch_req = 1'b0;
        check("req_rd", bus.imem_rd, 1);
        check("req_addr", bus.imem_addr, exp_addr);
        check("req_busy", bus.busy, 1);
        check("req_valid", bus.instr_valid, 0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = data;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'hDEAD_BEEF;
        check("rslv_valid", bus.instr_valid, 1);
        check("rslv_instr", bus.instr, data);
        check("rslv_opcode", bus.opcode, data[31:28]);
        check("rslv_mm", bus.mm, data[27:24]);
        check("rslv_rd", bus.imem_rd, 0);
        check("rslv_pc", bus.pc, exp_addr);
        @(negedge clk);
        check("post_valid", bus.instr_valid, 0);
        check("post_busy", bus.busy, 0);
        check("post_pc", bus.pc, exp_next);
        check("post_instr_hold", bus.instr, data);
        check("valid_pulses", vcount - v0, 1);
    endtask

    initial begin
        int v0;
        checks        = 0;
        errors        = 0;
        vcount        = 0;
        rst           = 1'b1;
        bus.fetch_req = 1'b0;
        bus.stat      = 4'b0000;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'h0;

        // Reset state
        @(negedge clk);
        check("rst_rd", bus.imem_rd, 0);
        check("rst_pc", bus.pc, 16'h0010);
        check("rst_instr", bus.instr, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_halted", bus.halted, 0);
        rst = 1'b0;

        // 1: immediate ack, opcode 8 -> sequential
        fetch(32'h8000_0000, 0, -1, 16'h0010, 16'h0011);

        // 2: ack delayed 4 cycles, stray request during wait is dropped
        fetch(32'h0000_0000, 4, 1, 16'h0011, 16'h0012);
        @(negedge clk);
        check("drop_rd", bus.imem_rd, 0);
        check("drop_busy", bus.busy, 0);

        // 3: bra to 0x20, bra to 0x100, brr -2 -> 0xFE
        fetch(32'h4000_0020, 0, -1, 16'h0012, 16'h0020);
        fetch(32'h4000_0100, 0, -1, 16'h0020, 16'h0100);
        fetch(32'h5000_FFFE, 0, -1, 16'h0100, 16'h00FE);

        // 4: bne mm=1 off=+5 at 0x30
        fetch(32'h4000_0030, 0, -1, 16'h00FE, 16'h0030);
        bus.stat = 4'b0000;
        fetch(32'h6100_0005, 0, -1, 16'h0030, 16'h0035);
        fetch(32'h4000_0030, 0, -1, 16'h0035, 16'h0030);
        bus.stat = 4'b0001;
        fetch(32'h6100_0005, 0, -1, 16'h0030, 16'h0031);
        bus.stat = 4'b1110;
        fetch(32'h6100_0005, 0, -1, 16'h0031, 16'h0036);
        bus.stat = 4'b0000;

        // 5: wrap 0xFFFF -> 0x0000, then hlt
        fetch(32'h4000_FFFF, 0, -1, 16'h0036, 16'hFFFF);
        fetch(32'h0000_0000, 0, -1, 16'hFFFF, 16'h0000);
        fetch(32'hF000_0000, 0, -1, 16'h0000, 16'h0000);
        check("hlt_halted", bus.halted, 1);
        v0 = vcount;
        @(negedge clk);
        bus.fetch_req = 1'b1;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h4000_1234;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        check("hlt_rd", bus.imem_rd, 0);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("hlt_rd2", bus.imem_rd, 0);
        check("hlt_busy", bus.busy, 0);
        check("hlt_pc", bus.pc, 16'h0000);
        check("hlt_instr", bus.instr, 32'hF000_0000);
        check("hlt_halted2", bus.halted, 1);
        check("hlt_pulses", vcount - v0, 0);

        // 6: leave halt by reset, then reset in the middle of REQ
        rst = 1'b1;
        @(negedge clk);
        check("unhalt", bus.halted, 0);
        rst = 1'b0;
        v0 = vcount;
        bus.fetch_req = 1'b1;
        @(negedge clk);
        bus.fetch_req = 1'b0;
        check("mid_rd_before", bus.imem_rd, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rd_async", bus.imem_rd, 0);
        check("mid_busy_async", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'h4000_1234;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("late_ack_instr", bus.instr, 0);
        check("late_ack_pc", bus.pc, 16'h0010);
        check("late_ack_rd", bus.imem_rd, 0);
        check("late_ack_busy", bus.busy, 0);
        @(negedge clk);
        check("late_ack_pulses", vcount - v0, 0);
        check("late_ack_valid", bus.instr_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
